conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Upstream feeder for `Convolution`: accepts a raster-order 8-bit pixel stream of an `IMG_W` x `IMG_H` image and emits every valid (unpadded) 3x3 window as nine parallel pixels with a one-cycle valid strobe. Two line buffers plus a 3x3 register window turn one pixel per cycle into one window per cycle once the pipeline is primed. Its outputs connect directly to `Convolution` `in_valid` / `In_IFM_1..9`. Weights are loaded separately and are out of scope.

## Interface
- `IMG_W`, default 8: pixels per row, legal range 3..256.
- `IMG_H`, default 8: rows per frame, legal range 3..256.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of counters and valid outputs; has priority over `pix_valid`.
- `pix_valid`  in  1  qualifies `pix_in`; gaps are allowed at any cycle.
- `pix_in`  in  8  unsigned pixel, raster order, row-major.
- `win_valid`  out  1  one-cycle strobe per window; drives `Convolution` `in_valid`.
- `win_1` .. `win_9`  out  8 each  window pixels, row-major: `win_1` is top-left (row r-2, col c-2); `win_9` is bottom-right, the current pixel (r, c).
- `frame_done`  out  1  one-cycle pulse together with the last window of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `pix_valid`. `col` wraps to 0 and increments `row`. At (IMG_H-1, IMG_W-1) both wrap to 0, so the next frame follows back-to-back with no idle cycle.
- Line buffer LB0 holds row r-1 and LB1 holds row r-2. Both are indexed by `col` and are circular, with no reset needed on their storage.
- On each accepted pixel:
  - The new column is {LB1[col], LB0[col], pix_in}.
  - Write LB1[col] <= LB0[col] and LB0[col] <= pix_in.
  - The 3x3 window shifts left by one column and loads the new column into the right column.
- A window is valid when `row >= 2` and `col >= 2`, evaluated on the accepted pixel's position. That gives (IMG_W-2)*(IMG_H-2) windows per frame.
- No cross-row contamination: a row-start window needs col >= 2, so three columns of the current row have been shifted in first.
- Stale line-buffer data from a prior frame is never emitted, because rows 0..1 of a new frame refill the buffers before any window is valid.
- `pix_valid` low: counters, line buffers and window hold; `win_valid` = 0 that cycle.
- `clr`:
  - Zeroes `row`, `col`, `win_valid` and `frame_done`.
  - `win_1..9` hold their values.
  - The pixel presented in the same cycle is discarded.
- States (encoded by the counters): FILL (row < 2), EDGE (row >= 2, col < 2), STREAM (row >= 2, col >= 2). Transitions occur only on accepted pixels.

## Timing
- Reset values: `win_valid` = 0, `frame_done` = 0, `win_1..9` = 0, `row` = `col` = 0.
- Latency: the window completed by the pixel accepted at edge N is presented after edge N, i.e. registered outputs valid in cycle N+1.
- `win_1..9` are stable for exactly the cycle `win_valid` = 1. They may change in other cycles.
- Throughput: one window per cycle with continuous input in STREAM.
- No backpressure: the consumer must accept every strobe.
- `frame_done` is asserted in the same cycle as the `win_valid` of window (IMG_H-1, IMG_W-1).
- Reset mid-frame: the next accepted pixel is treated as (0,0). No window may be emitted until two rows plus three pixels have been accepted.

## Structure
- Shared package `conv_pkg`: `PIX_W` = 8, `OFM_W` = 21, and a window-index constant ordering (1..9 row-major), shared with `Convolution` and the bench.
- Sub-module `conv_line_buffer`: a parameterised IMG_W-deep, 8-bit circular buffer with read-before-write at index `col`, instantiated twice.
- Counter, window-shift and valid logic live in the top module.

## Test plan
- IMG_W = IMG_H = 5, pixels 1..25 continuous:
  - first `win_valid` one cycle after pixel 13, with `win_1..9` = 1,2,3,6,7,8,11,12,13;
  - exactly 9 strobes;
  - last window 13,14,15,18,19,20,23,24,25 with `frame_done` = 1.
- Same stream with `pix_valid` toggled every other cycle: identical window sequence, strobes only after valid pixels, no window duplicated or skipped.
- Two back-to-back 5x5 frames, the second with values 101..125: second-frame first window = 101,102,103,106,107,108,111,112,113, with no first-frame pixel appearing.
- `rst_n` pulsed low after pixel 17:
  - outputs return to zero asynchronously;
  - a restarted 1..25 frame reproduces test 1 exactly.
- `clr` asserted together with pixel 10, then a fresh frame: the pixel is dropped, counters restart, and output matches test 1.
- IMG_W = 8, IMG_H = 4, ramp 0..31: 12 windows; the row-2 first window is 0,1,2,8,9,10,16,17,18; no window is emitted at col 0 or 1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: pixel/result widths
// and the row-major naming of the nine window taps.
package conv_pkg;

  localparam int PIX_W = 8;
  localparam int OFM_W = 21;
  localparam int WIN_N = 9;

  typedef logic [PIX_W-1:0] pix_t;

  // Window taps in row-major order: WIN_1 is top-left (oldest row, oldest
  // column), WIN_9 is bottom-right (the pixel just accepted).
  typedef enum int unsigned {
    WIN_1 = 0,
    WIN_2 = 1,
    WIN_3 = 2,
    WIN_4 = 3,
    WIN_5 = 4,
    WIN_6 = 5,
    WIN_7 = 6,
    WIN_8 = 7,
    WIN_9 = 8
  } win_idx_e;

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-stream in / window-stream out bundle of conv_window_gen.
// The master is the pixel source (and window consumer); the slave is
// the window generator itself.
interface conv_window_gen_if;
  import conv_pkg::*;

  logic pix_valid;
  pix_t pix_in;
  logic win_valid;
  pix_t win_1;
  pix_t win_2;
  pix_t win_3;
  pix_t win_4;
  pix_t win_5;
  pix_t win_6;
  pix_t win_7;
  pix_t win_8;
  pix_t win_9;
  logic frame_done;

  modport master (
    output pix_valid, pix_in,
    input  win_valid, win_1, win_2, win_3, win_4, win_5, win_6, win_7,
           win_8, win_9, frame_done
  );

  modport slave (
    input  pix_valid, pix_in,
    output win_valid, win_1, win_2, win_3, win_4, win_5, win_6, win_7,
           win_8, win_9, frame_done
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage. The read is combinational on the same
// address that is written, so a write at col returns the previous row's
// pixel for that column in the same cycle (read-before-write). Storage is
// deliberately unreset: stale contents are always overwritten before the
// window logic can use them.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pix_t          din,
  output pix_t          dout
);

  pix_t mem [DEPTH];

  assign dout = mem[addr];

  // Overwrite the column slot with the newer row's pixel on each accept.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster-order pixel stream into a stream of valid 3x3 windows.
// LB0 holds the previous row, LB1 the row before that; each accepted pixel
// forms a new window column {LB1[col], LB0[col], pix_in} that is shifted
// into the right side of the 3x3 register window.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  conv_window_gen_if.slave   bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // FILL: first two rows still loading the line buffers.
  // EDGE: first two columns of a later row; window not yet fully in-row.
  // STREAM: every accepted pixel completes a window.
  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_EDGE   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    state;
  logic          accept;
  logic          win_fire;
  logic          frame_end;
  pix_t          lb0_rd;
  pix_t          lb1_rd;
  pix_t          win [WIN_N];
  logic          win_valid_q;
  logic          frame_done_q;

  // A clear discards the pixel presented alongside it.
  assign accept    = bus.pix_valid & ~clr;
  assign win_fire  = accept & (state == ST_STREAM);
  assign frame_end = win_fire & (row == ROW_LAST) & (col == COL_LAST);

  // Position state is a pure decode of the raster counters.
  always_comb begin
    state = ST_FILL;
    if (row >= RW'(2)) begin
      state = (col >= CW'(2)) ? ST_STREAM : ST_EDGE;
    end
  end

  // Raster position of the next pixel; wraps straight into the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .din  (bus.pix_in),
    .dout (lb0_rd)
  );

  conv_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .we   (accept),
    .addr (col),
    .din  (lb0_rd),
    .dout (lb1_rd)
  );

  // Shift the window one column left and load the new column on the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) begin
        win[i] <= '0;
      end
    end else if (accept) begin
      win[WIN_1] <= win[WIN_2];
      win[WIN_2] <= win[WIN_3];
      win[WIN_3] <= lb1_rd;
      win[WIN_4] <= win[WIN_5];
      win[WIN_5] <= win[WIN_6];
      win[WIN_6] <= lb0_rd;
      win[WIN_7] <= win[WIN_8];
      win[WIN_8] <= win[WIN_9];
      win[WIN_9] <= bus.pix_in;
    end
  end

  // One-cycle strobes registered alongside the window they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (clr) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= win_fire;
      frame_done_q <= frame_end;
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.win_1      = win[WIN_1];
  assign bus.win_2      = win[WIN_2];
  assign bus.win_3      = win[WIN_3];
  assign bus.win_4      = win[WIN_4];
  assign bus.win_5      = win[WIN_5];
  assign bus.win_6      = win[WIN_6];
  assign bus.win_7      = win[WIN_7];
  assign bus.win_8      = win[WIN_8];
  assign bus.win_9      = win[WIN_9];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 5x5 instance (dut_a) and an 8x4
// instance (dut_b) share clock and reset. Expected windows come from the
// raster formula value(r,c) = base + r*W + c plus hand-written constants.
module tb_conv_window_gen;
  import conv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;

  always #5 clk = ~clk;

  conv_window_gen_if bus_a ();
  conv_window_gen_if bus_b ();

  conv_window_gen #(.IMG_W(5), .IMG_H(5)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_a),
    .bus   (bus_a)
  );

  conv_window_gen #(.IMG_W(8), .IMG_H(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_b),
    .bus   (bus_b)
  );

  int nChecks = 0;
  int nPass   = 0;
  int mr, mc, mW, mH;
  int strobes;
  logic [71:0] firstWin;
  logic [71:0] lastWin;
  logic        lastDone;

  function automatic logic [71:0] obsWin(input bit sel);
    if (sel)
      return {bus_b.win_1, bus_b.win_2, bus_b.win_3, bus_b.win_4, bus_b.win_5,
              bus_b.win_6, bus_b.win_7, bus_b.win_8, bus_b.win_9};
    return {bus_a.win_1, bus_a.win_2, bus_a.win_3, bus_a.win_4, bus_a.win_5,
            bus_a.win_6, bus_a.win_7, bus_a.win_8, bus_a.win_9};
  endfunction

  function automatic logic obsValid(input bit sel);
    return sel ? bus_b.win_valid : bus_a.win_valid;
  endfunction

  function automatic logic obsDone(input bit sel);
    return sel ? bus_b.frame_done : bus_a.frame_done;
  endfunction

  task automatic checkVal(input string tag, input logic [71:0] observed,
                          input logic [71:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic setIdle();
    bus_a.pix_valid = 1'b0;
    bus_a.pix_in    = '0;
    bus_b.pix_valid = 1'b0;
    bus_b.pix_in    = '0;
    clr_a           = 1'b0;
    clr_b           = 1'b0;
  endtask

  // Drive one cycle of input on the selected DUT, sample #1 after the edge.
  task automatic applyStimulus(input bit sel, input logic v, input pix_t p,
                               input logic c);
    @(negedge clk);
    bus_a.pix_valid = sel ? 1'b0 : v;
    bus_a.pix_in    = p;
    clr_a           = sel ? 1'b0 : c;
    bus_b.pix_valid = sel ? v : 1'b0;
    bus_b.pix_in    = p;
    clr_b           = sel ? c : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset(input int w, input int h);
    mr = 0;
    mc = 0;
    mW = w;
    mH = h;
    strobes = 0;
  endtask

  task automatic checkOutput(input bit sel, input bit accepted, input int base,
                             input string tag);
    logic        expValid;
    logic        expDone;
    logic [71:0] expWin;
    expValid = accepted && mr >= 2 && mc >= 2;
    expDone  = expValid && mr == mH - 1 && mc == mW - 1;
    expWin   = '0;
    checkVal({tag, " win_valid"}, 72'(obsValid(sel)), 72'(expValid));
    checkVal({tag, " frame_done"}, 72'(obsDone(sel)), 72'(expDone));
    if (expValid) begin
      for (int k = 0; k < 9; k++) begin
        expWin[71 - 8*k -: 8] = 8'(base + (mr - 2 + k / 3) * mW + (mc - 2 + k % 3));
      end
      checkVal({tag, " window"}, obsWin(sel), expWin);
    end
    if (obsValid(sel)) begin
      if (strobes == 0) firstWin = obsWin(sel);
      lastWin  = obsWin(sel);
      lastDone = obsDone(sel);
      strobes++;
    end
    if (accepted) begin
      mc++;
      if (mc == mW) begin
        mc = 0;
        mr++;
        if (mr == mH) mr = 0;
      end
    end
  endtask

  task automatic sendFrame(input bit sel, input int base, input int npix,
                           input bit gaps, input string tag);
    for (int i = 0; i < npix; i++) begin
      applyStimulus(sel, 1'b1, 8'(base + i), 1'b0);
      checkOutput(sel, 1'b1, base, tag);
      if (gaps) begin
        applyStimulus(sel, 1'b0, 8'hEE, 1'b0);
        checkOutput(sel, 1'b0, base, tag);
      end
    end
  endtask

  localparam logic [71:0] FIRST_A  = {8'd1, 8'd2, 8'd3, 8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13};
  localparam logic [71:0] LAST_A   = {8'd13, 8'd14, 8'd15, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd25};
  localparam logic [71:0] FIRST_A2 = {8'd101, 8'd102, 8'd103, 8'd106, 8'd107, 8'd108, 8'd111, 8'd112, 8'd113};
  localparam logic [71:0] FIRST_B  = {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
  localparam logic [71:0] LAST_B   = {8'd13, 8'd14, 8'd15, 8'd21, 8'd22, 8'd23, 8'd29, 8'd30, 8'd31};

  initial begin
    setIdle();

    // Reset state, sampled after an edge taken while reset is held.
    @(posedge clk);
    #1;
    checkVal("reset a valid", 72'(bus_a.win_valid), 72'(0));
    checkVal("reset a done", 72'(bus_a.frame_done), 72'(0));
    checkVal("reset a window", obsWin(1'b0), 72'(0));
    checkVal("reset b valid", 72'(bus_b.win_valid), 72'(0));
    checkVal("reset b window", obsWin(1'b1), 72'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous 5x5 frame 1..25.
    modelReset(5, 5);
    sendFrame(1'b0, 1, 25, 1'b0, "t1");
    checkVal("t1 strobes", 72'(strobes), 72'(9));
    checkVal("t1 first", firstWin, FIRST_A);
    checkVal("t1 last", lastWin, LAST_A);
    checkVal("t1 last done", 72'(lastDone), 72'(1));

    // Same frame with an idle cycle after every pixel.
    modelReset(5, 5);
    sendFrame(1'b0, 1, 25, 1'b1, "t2");
    checkVal("t2 strobes", 72'(strobes), 72'(9));
    checkVal("t2 first", firstWin, FIRST_A);
    checkVal("t2 last", lastWin, LAST_A);

    // Two back-to-back frames.
    modelReset(5, 5);
    sendFrame(1'b0, 1, 25, 1'b0, "t3a");
    checkVal("t3a strobes", 72'(strobes), 72'(9));
    strobes = 0;
    sendFrame(1'b0, 101, 25, 1'b0, "t3b");
    checkVal("t3b strobes", 72'(strobes), 72'(9));
    checkVal("t3b first", firstWin, FIRST_A2);
    checkVal("t3b last done", 72'(lastDone), 72'(1));

    // Asynchronous reset after pixel 17, then a full restart.
    modelReset(5, 5);
    sendFrame(1'b0, 1, 17, 1'b0, "t4pre");
    checkVal("t4 pre strobes", 72'(strobes), 72'(3));
    checkVal("t4 pre win_9", 72'(bus_a.win_9), 72'(17));
    setIdle();
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("t4 async valid", 72'(bus_a.win_valid), 72'(0));
    checkVal("t4 async done", 72'(bus_a.frame_done), 72'(0));
    checkVal("t4 async window", obsWin(1'b0), 72'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset(5, 5);
    sendFrame(1'b0, 1, 25, 1'b0, "t4");
    checkVal("t4 strobes", 72'(strobes), 72'(9));
    checkVal("t4 first", firstWin, FIRST_A);
    checkVal("t4 last", lastWin, LAST_A);

    // Clear presented together with pixel 10, then a fresh frame.
    modelReset(5, 5);
    sendFrame(1'b0, 1, 9, 1'b0, "t5pre");
    applyStimulus(1'b0, 1'b1, 8'd10, 1'b1);
    checkOutput(1'b0, 1'b0, 1, "t5clr");
    checkVal("t5 clr win_9 hold", 72'(bus_a.win_9), 72'(9));
    modelReset(5, 5);
    sendFrame(1'b0, 1, 25, 1'b0, "t5");
    checkVal("t5 strobes", 72'(strobes), 72'(9));
    checkVal("t5 first", firstWin, FIRST_A);
    checkVal("t5 last", lastWin, LAST_A);

    // 8x4 ramp 0..31 on the second instance.
    modelReset(8, 4);
    sendFrame(1'b1, 0, 32, 1'b0, "t6");
    checkVal("t6 strobes", 72'(strobes), 72'(12));
    checkVal("t6 first", firstWin, FIRST_B);
    checkVal("t6 last", lastWin, LAST_B);
    checkVal("t6 last done", 72'(lastDone), 72'(1));

    setIdle();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
